// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
//
// Single-channel bus initiator on the single-port data memory interface.
// Copies `len` 32-bit words from `src` to `dst` (mode=0) or fills `dst` with
// `fill_val` (mode=1). I/O space is reached transparently through the same
// port, so a copy can sample switches or drive LEDs like the core does.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   start, mode        one-cycle request (IDLE only), 0=copy / 1=fill
//   src, dst, len      source/destination byte address, word count
//   fill_val           fill pattern
//   abort              stop after the current bus cycle
//   m_we/m_addr/m_wd   memory write enable, byte address, write data
//   m_rd               memory read data, combinational from m_addr
//   busy               high while in RD or WR (arbiter grant request)
//   done               one-cycle pulse on completion, error or abort
//   err                sticky alignment error, cleared by next accepted start
//   words_done         words written in current or last transfer
// -----------------------------------------------------------------------------
module mem_copy_engine #(
    parameter int unsigned LEN_W   = 16,
    parameter logic [31:0] IO_BASE = 32'hC000_0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      fill_val,
    input  logic             abort,
    output logic             m_we,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_wd,
    input  logic [31:0]      m_rd,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done
);

    // The engine never decodes I/O addresses; it only relies on the I/O
    // window being word aligned so word-stepped transfers land on registers.
    if (IO_BASE[1:0] != 2'b00) begin : g_io_base_misaligned
        $error("IO_BASE must be word aligned");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_FIN
    } state_t;

    state_t             state_q;
    logic [31:0]        cur_src_q;
    logic [31:0]        cur_dst_q;
    logic [LEN_W-1:0]   len_q;
    logic               mode_q;
    logic [31:0]        fill_q;
    logic [LEN_W-1:0]   words_done_q;
    logic               m_we_q;
    logic [31:0]        m_addr_q;
    logic [31:0]        m_wd_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic [31:0]        src_inc_d;
    logic [31:0]        dst_inc_d;
    logic [LEN_W-1:0]   wd_inc_d;
    logic               last_d;
    logic               misalign_d;

    always_comb begin
        // Address arithmetic wraps modulo 2^32 by construction.
        src_inc_d  = cur_src_q + 32'd4;
        dst_inc_d  = cur_dst_q + 32'd4;
        wd_inc_d   = words_done_q + LEN_W'(1);
        last_d     = (wd_inc_d == len_q);
        // Source alignment only matters when the source is actually read.
        misalign_d = (!mode && (src[1:0] != 2'b00)) || (dst[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cur_src_q    <= '0;
            cur_dst_q    <= '0;
            len_q        <= '0;
            mode_q       <= 1'b0;
            fill_q       <= '0;
            words_done_q <= '0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wd_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cur_src_q    <= src;
                        cur_dst_q    <= dst;
                        len_q        <= len;
                        mode_q       <= mode;
                        fill_q       <= fill_val;
                        words_done_q <= '0;
                        err_q        <= misalign_d;
                        if (misalign_d || (len == '0)) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else if (mode) begin
                            state_q  <= S_WR;
                            busy_q   <= 1'b1;
                            m_we_q   <= 1'b1;
                            m_addr_q <= dst;
                            m_wd_q   <= fill_val;
                        end else begin
                            state_q  <= S_RD;
                            busy_q   <= 1'b1;
                            m_we_q   <= 1'b0;
                            m_addr_q <= src;
                        end
                    end
                end
                S_RD: begin
                    if (abort) begin
                        // Read finishes but its word is never written.
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        // m_wd doubles as the read data buffer.
                        state_q  <= S_WR;
                        m_we_q   <= 1'b1;
                        m_addr_q <= cur_dst_q;
                        m_wd_q   <= m_rd;
                    end
                end
                S_WR: begin
                    cur_dst_q    <= dst_inc_d;
                    words_done_q <= wd_inc_d;
                    if (!mode_q) begin
                        cur_src_q <= src_inc_d;
                    end
                    if (last_d || abort) begin
                        state_q <= S_FIN;
                        m_we_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (mode_q) begin
                        m_we_q   <= 1'b1;
                        m_addr_q <= dst_inc_d;
                        m_wd_q   <= fill_q;
                    end else begin
                        state_q  <= S_RD;
                        m_we_q   <= 1'b0;
                        m_addr_q <= src_inc_d;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign m_we       = m_we_q;
    assign m_addr     = m_addr_q;
    assign m_wd       = m_wd_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;

    localparam logic [31:0] IO_BASE = 32'hC000_0000;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        mode;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic [31:0] fill_val;
    logic        abort;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wd;
    logic [31:0] m_rd;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_done;

    logic [31:0] ram [0:255];
    logic [9:0]  switches;
    logic [9:0]  leds;
    int          ram_wr_cnt;
    bit          ram_init_done;

    int n_checks;
    int n_errors;

    mem_copy_engine #(
        .LEN_W  (16),
        .IO_BASE(IO_BASE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .mode      (mode),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .fill_val  (fill_val),
        .abort     (abort),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wd      (m_wd),
        .m_rd      (m_rd),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .words_done(words_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory + I/O model: RAM below IO_BASE, switches at IO_BASE, LEDs at +4.
    assign m_rd = (m_addr == IO_BASE) ? {22'b0, switches} :
                  (m_addr < IO_BASE)  ? ram[m_addr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'hA5A5_0000 + i;
            ram[0] <= 32'h11;
            ram[1] <= 32'h22;
            ram[2] <= 32'h33;
            ram[3] <= 32'h44;
            leds <= 10'h0;
            ram_wr_cnt <= 0;
            ram_init_done <= 1'b1;
        end else if (m_we) begin
            if (m_addr == IO_BASE + 32'd4) begin
                leds <= m_wd[9:0];
            end else if (m_addr < IO_BASE) begin
                ram[m_addr[9:2]] <= m_wd;
                ram_wr_cnt <= ram_wr_cnt + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Starts a transfer, waits for done (bounded) and reports the cycle on
    // which done was seen (start cycle = 0) and how many cycles had m_we=1.
    task automatic run_xfer(input logic md, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] l, input logic [31:0] fv,
                            input int abort_wr, input int restart_at,
                            output int done_cyc, output int we_cyc);
        int cyc;
        bit seen;
        mode = md; src = s; dst = d; len = l; fill_val = fv; start = 1'b1;
        cyc = 0; we_cyc = 0; done_cyc = -1; seen = 0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            if (cyc == restart_at) begin
                start = 1'b1;
                dst   = 32'h42;
                src   = 32'h1;
            end
            if (m_we) begin
                we_cyc++;
                if (we_cyc == abort_wr) abort = 1'b1;
            end
            if (done) begin
                seen = 1;
                done_cyc = cyc;
            end
        end
        if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        check_eq("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int dc, wc, wcnt;
        n_checks = 0; n_errors = 0;
        reset_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0;
        len = '0; fill_val = '0; abort = 1'b0; switches = 10'h2A5;
        ram_init_done = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_m_we", 32'(m_we), 32'd0);
        check_eq("rst_m_addr", m_addr, 32'd0);
        check_eq("rst_m_wd", m_wd, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_words_done", 32'(words_done), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Copy 4 words 0x00 -> 0x40
        run_xfer(1'b0, 32'h0, 32'h40, 16'd4, 32'h0, 0, 0, dc, wc);
        check_eq("copy_done_cyc", dc, 32'd9);
        check_eq("copy_we_cyc", wc, 32'd4);
        check_eq("copy_ram16", ram[16], 32'h11);
        check_eq("copy_ram17", ram[17], 32'h22);
        check_eq("copy_ram18", ram[18], 32'h33);
        check_eq("copy_ram19", ram[19], 32'h44);
        check_eq("copy_ram20_kept", ram[20], 32'hA5A5_0014);
        check_eq("copy_words_done", 32'(words_done), 32'd4);
        check_eq("copy_err", 32'(err), 32'd0);
        check_eq("copy_busy_after", 32'(busy), 32'd0);

        // Fill 3 words at 0x80
        run_xfer(1'b1, 32'h0, 32'h80, 16'd3, 32'hDEADBEEF, 0, 0, dc, wc);
        check_eq("fill_done_cyc", dc, 32'd4);
        check_eq("fill_we_cyc", wc, 32'd3);
        check_eq("fill_ram32", ram[32], 32'hDEADBEEF);
        check_eq("fill_ram33", ram[33], 32'hDEADBEEF);
        check_eq("fill_ram34", ram[34], 32'hDEADBEEF);
        check_eq("fill_ram35_kept", ram[35], 32'hA5A5_0023);
        check_eq("fill_words_done", 32'(words_done), 32'd3);

        // Switches -> LEDs through I/O space
        wcnt = ram_wr_cnt;
        run_xfer(1'b0, IO_BASE, IO_BASE + 32'd4, 16'd1, 32'h0, 0, 0, dc, wc);
        check_eq("io_leds", 32'(leds), 32'h2A5);
        check_eq("io_ram_untouched", ram_wr_cnt, wcnt);
        check_eq("io_done_cyc", dc, 32'd3);

        // Misaligned destination is rejected
        run_xfer(1'b0, 32'h0, 32'h42, 16'd2, 32'h0, 0, 0, dc, wc);
        check_eq("err_flag", 32'(err), 32'd1);
        check_eq("err_done_cyc", dc, 32'd1);
        check_eq("err_no_we", wc, 32'd0);
        check_eq("err_words_done", 32'(words_done), 32'd0);

        // len=0 is accepted, clears err, no writes
        wcnt = ram_wr_cnt;
        run_xfer(1'b0, 32'h0, 32'h40, 16'd0, 32'h0, 0, 0, dc, wc);
        check_eq("len0_err_clr", 32'(err), 32'd0);
        check_eq("len0_done_cyc", dc, 32'd1);
        check_eq("len0_no_we", wc, 32'd0);
        check_eq("len0_no_ram_wr", ram_wr_cnt, wcnt);

        // Fill ignores source alignment
        run_xfer(1'b1, 32'h3, 32'h100, 16'd1, 32'h5A, 0, 0, dc, wc);
        check_eq("fill_src_odd_err", 32'(err), 32'd0);
        check_eq("fill_src_odd_ram64", ram[64], 32'h5A);

        // Abort in the 3rd WR cycle of an 8-word copy
        run_xfer(1'b0, 32'h0, 32'h200, 16'd8, 32'h0, 3, 0, dc, wc);
        check_eq("abort_words_done", 32'(words_done), 32'd3);
        check_eq("abort_we_cyc", wc, 32'd3);
        check_eq("abort_done_cyc", dc, 32'd7);
        check_eq("abort_ram128", ram[128], 32'h11);
        check_eq("abort_ram130", ram[130], 32'h33);
        check_eq("abort_ram131_kept", ram[131], 32'hA5A5_0083);

        // Start while busy is ignored
        run_xfer(1'b0, 32'h0, 32'h300, 16'd2, 32'h0, 0, 2, dc, wc);
        check_eq("ign_done_cyc", dc, 32'd5);
        check_eq("ign_we_cyc", wc, 32'd2);
        check_eq("ign_err", 32'(err), 32'd0);
        check_eq("ign_ram192", ram[192], 32'h11);
        check_eq("ign_ram193", ram[193], 32'h22);
        repeat (3) @(posedge clk);
        #1;
        check_eq("ign_no_second", 32'(busy), 32'd0);

        // Reset dropped during an RD cycle
        mode = 1'b0; src = 32'h0; dst = 32'h380; len = 16'd8; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rstx_busy_before", 32'(busy), 32'd1);
        check_eq("rstx_in_rd", 32'(m_we), 32'd0);
        wcnt = ram_wr_cnt;
        #2 reset_n = 1'b0;
        #1;
        check_eq("rstx_m_we", 32'(m_we), 32'd0);
        check_eq("rstx_m_addr", m_addr, 32'd0);
        check_eq("rstx_busy", 32'(busy), 32'd0);
        check_eq("rstx_words_done", 32'(words_done), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("rstx_no_more_wr", ram_wr_cnt, wcnt);
        check_eq("rstx_ram224_kept", ram[224], 32'h11);
        check_eq("rstx_ram225_unwritten", ram[225], 32'hA5A5_00E1);

        // Destination address wraps past 0xFFFF_FFFC to 0
        run_xfer(1'b1, 32'h0, 32'hFFFF_FFF8, 16'd3, 32'h0BAD_F00D, 0, 0, dc, wc);
        check_eq("wrap_ram0", ram[0], 32'h0BAD_F00D);
        check_eq("wrap_err", 32'(err), 32'd0);
        check_eq("wrap_words_done", 32'(words_done), 32'd3);
        check_eq("wrap_addr_hold", m_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
